// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants: instruction word layout, PC increment and FSM encodings.
package cpu_defs;
    localparam int INSTR_W = 32;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int OP_W    = OP_MSB - OP_LSB + 1;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem req/ack, decode valid/ready and the execute redirect.
interface instr_fetch_if #(parameter int AW = 32);
    import cpu_defs::*;

    logic               imem_req;
    logic [AW-1:0]      imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [AW-1:0]      id_pc;
    logic [OP_W-1:0]    id_op;
    logic               redirect_valid;
    logic [AW-1:0]      redirect_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_op,
        input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_op,
        output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Sync FIFO for fetched words; a push is visible at the head one cycle later (no bypass).
// Flush wins over push/pop; caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, single-outstanding imem fetch FSM, credit-gated FIFO toward decode.
// Ack in cycle N shows on id_* in N+1; no request is issued unless a FIFO slot is reserved.
module instr_fetch
    import cpu_defs::*;
#(
    parameter int            AW         = 32,
    parameter logic [AW-1:0] RESET_PC   = '0,
    parameter int            FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = INSTR_W + AW;

    fetch_state_t  r_state;
    fetch_state_t  w_next_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_next_pc;
    logic [AW-1:0] w_redir_pc;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_next;
    logic [DW-1:0] w_head;
    logic          w_inflight;
    logic          w_credit_ok;
    logic          w_id_valid;
    logic          w_push;
    logic          w_pop;

    assign w_inflight  = (r_state != ST_IDLE);
    assign w_credit_ok = (w_count + CW'(w_inflight)) < CW'(FIFO_DEPTH);
    assign w_id_valid  = (w_count != '0);
    assign w_redir_pc  = bus.redirect_pc & ~AW'(3);

    // Redirect squashes both the acked word and the decode pop in its cycle.
    assign w_push     = (r_state == ST_REQ) && bus.imem_ack && !bus.redirect_valid;
    assign w_pop      = w_id_valid && bus.id_ready && !bus.redirect_valid;
    assign w_cnt_next = w_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (w_credit_ok) w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    w_next_pc    = r_pc + AW'(PC_INC);
                    w_next_state = (w_cnt_next < CW'(FIFO_DEPTH)) ? ST_REQ : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (bus.imem_ack) w_next_state = ST_REQ;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (bus.redirect_valid) begin
            w_next_pc    = w_redir_pc;
            w_next_state = (w_inflight && !bus.imem_ack) ? ST_FLUSH : ST_REQ;
        end
    end

    // The address only moves once the bus is free, so a stale request is held through FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_addr  <= (w_next_state == ST_FLUSH) ? r_addr : w_next_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat ({bus.imem_rdata, r_pc}),
        .i_pop      (w_pop),
        .i_flush    (bus.redirect_valid),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    assign bus.imem_req  = w_inflight;
    assign bus.imem_addr = r_addr;
    assign bus.id_valid  = w_id_valid;
    assign bus.id_instr  = w_head[AW +: INSTR_W];
    assign bus.id_pc     = w_head[AW-1:0];
    assign bus.id_op     = bus.id_instr[OP_MSB:OP_LSB];
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with a queue-based reference model and directed scenarios.
module tb_instr_fetch;
    import cpu_defs::*;

    localparam int          AW    = 32;
    localparam logic [31:0] RPC   = 32'h100;
    localparam int          DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.AW(AW)) bus();

    instr_fetch #(.AW(AW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: buffered words, next fetch PC, and the one outstanding request.
    ent_t        m_q[$];
    logic [31:0] m_pc   = RPC;
    logic [31:0] m_addr = RPC;
    logic        m_busy = 1'b0;
    logic        m_drop = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic [31:0] ack_addr[$];

    int          ready_mode = 1;
    int          lat_min = 1, lat_max = 1;
    int          redir_pct = 0;
    logic        fix_rd_en = 1'b0;
    logic [31:0] fix_rd = '0;
    int          wait_cnt = 0, cur_lat = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [31:0] q[$], input int idx,
                           input logic [31:0] exp);
        if (idx < q.size()) check(name, q[idx], exp);
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: actual <missing, only %0d entries> required %h", name, q.size(), exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = RPC;
        m_addr = RPC;
        m_busy = 1'b0;
        m_drop = 1'b0;
    endtask

    // One clock edge of the fetch rules, applied to the inputs present at that edge.
    task automatic model_step();
        int          occ;
        logic        pop;
        logic [31:0] npc;
        if (!rst_n) return;
        occ = m_q.size();
        pop = (occ != 0) && bus.id_ready;
        if (bus.redirect_valid) begin
            m_q.delete();
            npc = {bus.redirect_pc[31:2], 2'b00};
            if (m_busy && !bus.imem_ack) m_drop = 1'b1;
            else begin
                m_busy = 1'b1;
                m_drop = 1'b0;
                m_addr = npc;
            end
            m_pc = npc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy && bus.imem_ack) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_addr = m_pc;
                end else begin
                    m_q.push_back({bus.imem_rdata, m_pc});
                    m_pc   = m_pc + 32'd4;
                    m_busy = (m_q.size() < DEPTH);
                    m_addr = m_pc;
                end
            end else if (!m_busy && occ < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic drive_inputs();
        bus.id_ready       = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        bus.redirect_valid = 1'b0;
        if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = $urandom;
        end
        bus.imem_ack = 1'b0;
        if (bus.imem_req) begin
            if (wait_cnt >= cur_lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = fix_rd_en ? fix_rd : $urandom;
                wait_cnt       = 0;
                cur_lat        = $urandom_range(lat_min, lat_max);
            end else wait_cnt++;
        end else wait_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        drive_inputs();
    endtask

    task automatic reset_literals();
        check("rst_imem_req",  bus.imem_req,  32'd0);
        check("rst_imem_addr", bus.imem_addr, RPC);
        check("rst_id_valid",  bus.id_valid,  32'd0);
        check("rst_id_instr",  bus.id_instr,  32'd0);
        check("rst_id_pc",     bus.id_pc,     32'd0);
        check("rst_id_op",     bus.id_op,     32'd0);
    endtask

    // Asserted a few ns after an edge so the async path is exercised away from the clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        wait_cnt           = 0;
        #1;
        reset_literals();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_mode(input int rdy, input int lmin, input int lmax, input int rpct);
        ready_mode = rdy;
        lat_min    = lmin;
        lat_max    = lmax;
        cur_lat    = lmin;
        redir_pct  = rpct;
    endtask

    always @(negedge clk) begin
        check("imem_req",  bus.imem_req,  m_busy);
        check("imem_addr", bus.imem_addr, m_busy ? m_addr : m_pc);
        check("id_valid",  bus.id_valid,  m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("id_instr", bus.id_instr, m_q[0].instr);
            check("id_pc",    bus.id_pc,    m_q[0].pc);
            check("id_op",    bus.id_op,    m_q[0].instr[31:27]);
        end
        if (rst_n && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
            pop_pc.push_back(bus.id_pc);
            pop_instr.push_back(bus.id_instr);
        end
        if (rst_n && bus.imem_req && bus.imem_ack) ack_addr.push_back(bus.imem_addr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int deadbeef_seen;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 reset_literals();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Sequential fetch from RESET_PC with one-cycle ack latency.
        set_mode(1, 1, 1, 0);
        pop_pc.delete();
        ack_addr.delete();
        repeat (12) tick();
        check_q("p1_pop0", pop_pc, 0, 32'h100);
        check_q("p1_pop1", pop_pc, 1, 32'h104);
        check_q("p1_pop2", pop_pc, 2, 32'h108);
        check_q("p1_ack0", ack_addr, 0, 32'h100);
        check_q("p1_ack2", ack_addr, 2, 32'h108);
        tick();
        do_reset();

        // Decode stalled: exactly DEPTH words fetched, then the bus goes quiet.
        set_mode(0, 0, 2, 0);
        fix_rd_en = 1'b1;
        fix_rd    = 32'hA000_0000;
        ack_addr.delete();
        repeat (20) tick();
        check("p2_nack",    ack_addr.size(), 32'd2);
        check("p2_req_off", bus.imem_req,    32'd0);
        check("p2_valid",   bus.id_valid,    32'd1);
        check("p2_instr",   bus.id_instr,    32'hA000_0000);
        check("p2_op",      bus.id_op,       32'd20);
        check("p2_pc",      bus.id_pc,       32'h100);
        fix_rd_en = 1'b0;
        ready_mode = 1;
        pop_pc.delete();
        repeat (16) tick();
        check_q("p2_pop0", pop_pc, 0, 32'h100);
        check_q("p2_pop1", pop_pc, 1, 32'h104);
        check_q("p2_pop2", pop_pc, 2, 32'h108);
        check_q("p2_pop3", pop_pc, 3, 32'h10C);

        // Redirect while idle with a full FIFO.
        set_mode(0, 0, 0, 0);
        repeat (10) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        tick();
        check("p4_valid", bus.id_valid,  32'd0);
        check("p4_req",   bus.imem_req,  32'd1);
        check("p4_addr",  bus.imem_addr, 32'h200);
        ready_mode = 1;
        pop_pc.delete();
        repeat (8) tick();
        check_q("p4_pop0", pop_pc, 0, 32'h200);

        // Redirect in the same cycle as an ack: that word must never reach decode.
        set_mode(1, 1, 1, 0);
        for (int k = 0; k < 20 && !bus.imem_ack; k++) tick();
        check("p4b_ack_seen", bus.imem_ack, 32'd1);
        bus.imem_rdata     = 32'hDEAD_BEEF;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        pop_pc.delete();
        pop_instr.delete();
        repeat (10) tick();
        check_q("p4b_pop0", pop_pc, 0, 32'h300);
        deadbeef_seen = 0;
        foreach (pop_instr[i]) if (pop_instr[i] == 32'hDEAD_BEEF) deadbeef_seen++;
        check("p4b_dropped", deadbeef_seen, 32'd0);

        // Redirect while a slow request is outstanding: FLUSH holds the old address.
        do_reset();
        set_mode(1, 3, 3, 0);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h500;
        tick();
        check("p5_req",    bus.imem_req,  32'd1);
        check("p5_addr",   bus.imem_addr, 32'h100);
        check("p5_valid",  bus.id_valid,  32'd0);
        tick();
        check("p5_hold1",  bus.imem_addr, 32'h100);
        tick();
        check("p5_hold2",  bus.imem_addr, 32'h100);
        pop_pc.delete();
        tick();
        check("p5_newreq", bus.imem_req,  32'd1);
        check("p5_newadr", bus.imem_addr, 32'h500);
        repeat (20) tick();
        check_q("p5_pop0", pop_pc, 0, 32'h500);

        // PC wraps at the top of the address space.
        set_mode(1, 0, 0, 0);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        pop_pc.delete();
        repeat (10) tick();
        check_q("p6_pop0", pop_pc, 0, 32'hFFFF_FFFC);
        check_q("p6_pop1", pop_pc, 1, 32'h0);

        // Random traffic: ready, latency and redirects all randomized, with one reset.
        set_mode(2, 0, 3, 6);
        repeat (300) tick();
        do_reset();
        repeat (300) tick();
        set_mode(1, 0, 3, 0);
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
